hrmf_ctrl: RTL and testbench
============================

HRMF_CTRL -- requirements
Module: hrmf_ctrl

Interface
REQ-001 The block SHALL have parameter LAT_MTU0, default 3, meaning cycles from the MTU4X4 input to its aligned output.
REQ-002 The block SHALL have parameter LAT_ETU, default 12, meaning cycles from the ETU4X4 input to its aligned output.
REQ-003 The block SHALL have parameter FRAME_BEATS, default 16, meaning beats per 64-point frame at 4 samples per beat.
REQ-004 The block SHALL have port CLK, input, 1, the single clock.
REQ-005 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port IN_VALID, input, 1, meaning D0..D3 of HRMF carry a beat this cycle.
REQ-007 The block SHALL have port IN_SOF, input, 1, meaning this beat is beat 0 of a frame.
REQ-008 The block SHALL have port SEL_ROT0, output, 4, the ROTATOR0 stage enables.
REQ-009 The block SHALL have port SEL_MTU0, output, 2, the MTU4X4 switch selects.
REQ-010 The block SHALL have port SEL_ROT1, output, 2, the ROTATOR1 stage enables.
REQ-011 The block SHALL have port SEL_MTU1, output, 2, the ETU4X4 switch selects.
REQ-012 The block SHALL have port TF_ADDR, output, 4, the twiddle ROM index for TF0..TF3.
REQ-013 The block SHALL have ports OUT_VALID, OUT_SOF, OUT_EOF, output, 1 each, qualifying Q0..Q3.
REQ-014 The block SHALL have port FRAME_ERR, output, 1, a one-cycle protocol-violation pulse.

Function
REQ-015 The block SHALL implement an FSM with states IDLE and RUN and a 4-bit beat counter cnt.
REQ-016 In IDLE, IN_VALID&IN_SOF SHALL accept beat 0, set cnt to 1 and enter RUN.
REQ-017 In IDLE, IN_VALID&!IN_SOF SHALL drop the beat, pulse FRAME_ERR and stay in IDLE.
REQ-018 In RUN, IN_VALID&!IN_SOF SHALL accept beat cnt; cnt==15 SHALL return to IDLE with cnt=0, so a back-to-back SOF on the next cycle is accepted.
REQ-019 In RUN, !IN_VALID SHALL pulse FRAME_ERR, return to IDLE, set cnt to 0 and clear every valid bit in the tracking pipe.
REQ-020 In RUN, IN_VALID&IN_SOF SHALL pulse FRAME_ERR, clear the tracking pipe and accept the beat as beat 0 of a new frame (cnt=1, stay in RUN).
REQ-021 The block SHALL hold a shift pipe of entries {valid, beat[3:0], sof, eof}, where p0 is the accepted beat this cycle and pk is the entry k cycles older, with depth LAT_MTU0+LAT_ETU.
REQ-022 SEL_ROT0 SHALL be combinational from p0 and equal bitreverse(beat), with SEL_ROT0[0]=beat[3] and SEL_ROT0[3]=beat[0].
REQ-023 SEL_MTU0 SHALL be {p2.beat[1], p3.beat[0]}.
REQ-024 SEL_ROT1 SHALL be {p3.beat[2], p3.beat[3]}.
REQ-025 SEL_MTU1 SHALL be {p11.beat[3], p13.beat[2]}.
REQ-026 Each select field SHALL drive 0 when its source entry is invalid.
REQ-027 TF_ADDR SHALL equal p15.beat; OUT_VALID, OUT_SOF and OUT_EOF SHALL equal p15 valid, sof and eof, giving a latency of LAT_MTU0+LAT_ETU = 15 cycles.
REQ-028 When p15 is invalid, TF_ADDR SHALL be 0 and OUT_SOF and OUT_EOF SHALL be 0.
REQ-029 eof SHALL be set only on accepted beat 15.
REQ-030 A frame aborted per REQ-019/REQ-020 SHALL produce no OUT_VALID for any of its beats, or for older in-flight beats.
REQ-031 All counter arithmetic SHALL be unsigned modulo 16.

Reset
REQ-032 RST high SHALL asynchronously force IDLE, cnt=0 and all pipe entries invalid.
REQ-033 During reset, all outputs SHALL be 0, including FRAME_ERR.
REQ-034 Reset asserted mid-frame SHALL discard that frame; the first accepted beat after release SHALL require IN_SOF.

Structure
REQ-035 LAT_MTU0, LAT_ETU, FRAME_BEATS, the state encoding and the pipe-entry record SHALL live in a shared package, hrmf_pkg.
REQ-036 The pipe SHALL be one sub-module, hrmf_tag_pipe, with a synchronous flush input and tap outputs at 2, 3, 11, 13 and 15.

Verification
REQ-037 One frame (SOF at t0, 16 continuous beats) -> SEL_ROT0 sequence 0,8,4,C,...,F; OUT_VALID t15..t30; OUT_SOF at t15; OUT_EOF at t30; TF_ADDR 0..15.
REQ-038 Two back-to-back frames -> 32 continuous OUT_VALID cycles, OUT_SOF at t15 and t31, FRAME_ERR never asserted.
REQ-039 IN_VALID dropped at beat 7 -> FRAME_ERR pulse that cycle, no OUT_VALID from that frame, next SOF accepted normally.
REQ-040 IN_VALID without SOF in IDLE -> FRAME_ERR pulse, all outputs stay 0.
REQ-041 SOF reasserted at beat 9 -> FRAME_ERR, new frame output starting 15 cycles later with OUT_SOF.
REQ-042 RST pulsed at beat 5 -> all outputs 0 at once, no OUT_VALID until 15 cycles after the next SOF.

Source files
------------

// File: rtl/hrmf_pkg.sv
// hrmf_pkg: shared latencies, FSM encoding and tracking-pipe entry for the HRMF controller.
package hrmf_pkg;

    localparam int LAT_MTU0 = 3;
    localparam int LAT_ETU = 12;
    localparam int FRAME_BEATS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] beat;
        logic       sof;
        logic       eof;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic logic [3:0] bitrev4(input logic [3:0] b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

endpackage

// File: rtl/hrmf_tag_pipe.sv
// hrmf_tag_pipe: delay line of beat tags; flush drops everything in flight but still loads the incoming tag.
module hrmf_tag_pipe
    import hrmf_pkg::*;
#(
    parameter int DEPTH = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic [TAG_W-1:0] din,
    output logic [TAG_W-1:0] tap2,
    output logic [TAG_W-1:0] tap3,
    output logic [TAG_W-1:0] tap11,
    output logic [TAG_W-1:0] tap13,
    output logic [TAG_W-1:0] tap15
);

    tag_t pipe [DEPTH:1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 1; i <= DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[1] <= din;
            for (int i = 2; i <= DEPTH; i++) pipe[i] <= flush ? '0 : pipe[i-1];
        end
    end

    assign tap2  = pipe[2];
    assign tap3  = pipe[3];
    assign tap11 = pipe[11];
    assign tap13 = pipe[13];
    assign tap15 = pipe[DEPTH];

endmodule

// File: rtl/hrmf_ctrl.sv
// hrmf_ctrl: frame tracker for the HRMF datapath; tags each accepted beat and derives
// rotator/switch selects and twiddle addresses from the tag's position in the latency pipe.
module hrmf_ctrl #(
    parameter int LAT_MTU0 = hrmf_pkg::LAT_MTU0,
    parameter int LAT_ETU = hrmf_pkg::LAT_ETU,
    parameter int FRAME_BEATS = hrmf_pkg::FRAME_BEATS
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic       IN_SOF,
    output logic [3:0] SEL_ROT0,
    output logic [1:0] SEL_MTU0,
    output logic [1:0] SEL_ROT1,
    output logic [1:0] SEL_MTU1,
    output logic [3:0] TF_ADDR,
    output logic       OUT_VALID,
    output logic       OUT_SOF,
    output logic       OUT_EOF,
    output logic       FRAME_ERR
);

    import hrmf_pkg::*;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       last, run_beat, accept, flush;
    tag_t       p0, t2, t3, t11, t13, t15;
    logic       unused;

    assign last     = cnt == 4'(FRAME_BEATS - 1);
    assign run_beat = state == RUN && IN_VALID && !IN_SOF;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A SOF beat always opens a frame, even when it interrupts one already running.
    always_comb begin
        state_nx = (IN_VALID && IN_SOF) ? RUN : (run_beat && !last) ? RUN : IDLE;
        cnt_nx   = (IN_VALID && IN_SOF) ? 4'd1 : run_beat ? (last ? 4'd0 : cnt + 4'd1) : 4'd0;
    end

    always_comb begin
        accept    = !RST && IN_VALID && (IN_SOF || state == RUN);
        FRAME_ERR = !RST && ((state == IDLE) ? (IN_VALID && !IN_SOF) : (!IN_VALID || IN_SOF));
        flush     = state == RUN && (!IN_VALID || IN_SOF);
        p0        = '0;
        p0.valid  = accept;
        p0.beat   = (accept && !IN_SOF) ? cnt : 4'd0;
        p0.sof    = accept && IN_SOF;
        p0.eof    = accept && !IN_SOF && last;
    end

    hrmf_tag_pipe #(.DEPTH(LAT_MTU0 + LAT_ETU)) u_pipe (
        .CLK   (CLK),
        .RST   (RST),
        .flush (flush),
        .din   (p0),
        .tap2  (t2),
        .tap3  (t3),
        .tap11 (t11),
        .tap13 (t13),
        .tap15 (t15)
    );

    assign SEL_ROT0  = p0.valid ? bitrev4(p0.beat) : 4'd0;
    assign SEL_MTU0  = {t2.valid & t2.beat[1], t3.valid & t3.beat[0]};
    assign SEL_ROT1  = {t3.valid & t3.beat[2], t3.valid & t3.beat[3]};
    assign SEL_MTU1  = {t11.valid & t11.beat[3], t13.valid & t13.beat[2]};
    assign TF_ADDR   = t15.valid ? t15.beat : 4'd0;
    assign OUT_VALID = t15.valid;
    assign OUT_SOF   = t15.valid & t15.sof;
    assign OUT_EOF   = t15.valid & t15.eof;
    assign unused    = ^{t2, t3, t11, t13};

endmodule

// File: tb/tb_hrmf_ctrl.sv
// tb_hrmf_ctrl: directed scenarios plus random frames, checked against a beat-history model and an output scoreboard.
module tb_hrmf_ctrl;

    localparam int N = 4096;

    logic       CLK = 0, RST = 1, IN_VALID = 0, IN_SOF = 0;
    logic [3:0] SEL_ROT0, TF_ADDR;
    logic [1:0] SEL_MTU0, SEL_ROT1, SEL_MTU1;
    logic       OUT_VALID, OUT_SOF, OUT_EOF, FRAME_ERR;

    hrmf_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_SOF    (IN_SOF),
        .SEL_ROT0  (SEL_ROT0),
        .SEL_MTU0  (SEL_MTU0),
        .SEL_ROT1  (SEL_ROT1),
        .SEL_MTU1  (SEL_MTU1),
        .TF_ADDR   (TF_ADDR),
        .OUT_VALID (OUT_VALID),
        .OUT_SOF   (OUT_SOF),
        .OUT_EOF   (OUT_EOF),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         due;
        logic [3:0] beat;
        logic       sof;
        logic       eof;
    } exp_t;

    int         cyc = 0;
    bit         acc [N];
    bit         flsh [N];
    bit         rsth [N];
    bit         err_x [N];
    logic [3:0] bt [N];
    exp_t       q [$];
    int         n_vec = 0, n_bad = 0;
    bit         in_frame = 0, live = 0;
    int         nb = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, a, e);
        end
    endtask

    // A beat accepted at cycle c survives to cycle t unless a frame abort occurred strictly
    // between c and t, or reset was high at any cycle after c up to and including t.
    function automatic bit alive(input int t, input int k);
        int c;
        c = t - k;
        if (c < 1 || !acc[c]) return 0;
        for (int f = c + 1; f < t; f++) if (flsh[f]) return 0;
        for (int r = c + 1; r <= t; r++) if (rsth[r]) return 0;
        return 1;
    endfunction

    function automatic logic tbit(input int t, input int k, input int i);
        logic [3:0] b;
        if (!alive(t, k)) return 1'b0;
        b = bt[t-k];
        return b[i];
    endfunction

    task automatic purge();
        exp_t keep [$];
        foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
        q = keep;
    endtask

    task automatic take(input logic [3:0] b, input logic s, input logic e);
        acc[cyc] = 1;
        bt[cyc]  = b;
        q.push_back('{cyc + 15, b, s, e});
    endtask

    task automatic step(input bit v, input bit s, input bit r);
        @(posedge CLK);
        #1;
        RST = r; IN_VALID = v; IN_SOF = s;
        live = 1;
        acc[cyc] = 0; flsh[cyc] = 0; rsth[cyc] = r; err_x[cyc] = 0; bt[cyc] = 0;
        if (r) begin
            in_frame = 0; nb = 0; q.delete();
        end else if (v && s) begin
            if (in_frame) begin err_x[cyc] = 1; flsh[cyc] = 1; purge(); end
            take(4'd0, 1'b1, 1'b0);
            in_frame = 1; nb = 1;
        end else if (v) begin
            if (!in_frame) err_x[cyc] = 1;
            else begin
                take(4'(nb), 1'b0, nb == 15);
                nb++;
                if (nb == 16) begin in_frame = 0; nb = 0; end
            end
        end else if (in_frame) begin
            err_x[cyc] = 1; flsh[cyc] = 1; purge(); in_frame = 0; nb = 0;
        end
    endtask

    task automatic frame(input int n);
        step(1, 1, 0);
        for (int i = 1; i < n; i++) step(1, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    always @(negedge CLK) begin : mon
        exp_t       e;
        logic [3:0] b0;
        if (live) begin
            b0 = bt[cyc];
            chk("frame_err", FRAME_ERR, err_x[cyc]);
            chk("sel_rot0", SEL_ROT0, alive(cyc, 0) ? {b0[0], b0[1], b0[2], b0[3]} : 4'd0);
            chk("sel_mtu0", SEL_MTU0, {tbit(cyc, 2, 1), tbit(cyc, 3, 0)});
            chk("sel_rot1", SEL_ROT1, {tbit(cyc, 3, 2), tbit(cyc, 3, 3)});
            chk("sel_mtu1", SEL_MTU1, {tbit(cyc, 11, 3), tbit(cyc, 13, 2)});
            chk("tf_addr_tap", TF_ADDR, alive(cyc, 15) ? bt[cyc-15] : 4'd0);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("out_valid", OUT_VALID, 1);
                chk("out_beat", TF_ADDR, e.beat);
                chk("out_sof", OUT_SOF, e.sof);
                chk("out_eof", OUT_EOF, e.eof);
            end else begin
                chk("out_valid_idle", OUT_VALID, 0);
                chk("out_sof_idle", OUT_SOF, 0);
                chk("out_eof_idle", OUT_EOF, 0);
            end
        end
    end

    initial begin
        int r;
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        idle(2);
        frame(16); frame(16); idle(20);
        frame(7); step(0, 0, 0); frame(16); idle(18);
        step(1, 0, 0); step(1, 0, 0); idle(18);
        frame(9); frame(16); idle(18);
        frame(5); step(1, 0, 1); step(0, 0, 0); step(1, 0, 0); frame(16); idle(18);
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
            else if (in_frame) step(r >= 6, r >= 6 && r < 10, 0);
            else step(r < 58, r < 50, 0);
        end
        idle(20);
        @(negedge CLK);
        #1;
        chk("scoreboard_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
